// File: rtl/core_pkg.sv
// Shared types and constants for the pipeline control blocks.
package core_pkg;

  localparam int unsigned REG_W = 5;
  localparam logic [REG_W-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    ERR      = 2'd3
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/hazard_sequencer.sv
// Hazard/stall controller for the 5-stage core: memory-wait freeze, load-use
// bubble, taken-branch IF/ID flush, performance counters and timeout error.
module hazard_sequencer
  import core_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic             id_uses_rs2_i,
  input  logic             ex_memread_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             ctrl_flush_o,
  output logic             pipe_stall_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             err_o
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t            state;
  state_t            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [8:0]        wait_inc;
  logic              lu;
  logic              mm;
  logic              stall_inc;
  logic              flush_inc;

  assign lu = ex_memread_i && (ex_rd_i != ZERO_REG) &&
              ((ex_rd_i == id_rs1_i) || (id_uses_rs2_i && (ex_rd_i == id_rs2_i)));
  assign mm       = mem_req_i && !mem_ready_i;
  assign wait_inc = 9'(wait_cnt) + 9'd1;

  // Zero-latency control outputs and next state; IDLE/ERR hold the pipe frozen.
  always_comb begin
    state_nxt    = state;
    pc_write_o   = 1'b0;
    ifid_write_o = 1'b0;
    ifid_flush_o = 1'b0;
    ctrl_flush_o = 1'b1;
    pipe_stall_o = 1'b1;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) state_nxt = RUN;
      end
      RUN: begin
        if (mm) begin
          ctrl_flush_o = 1'b0;
          stall_inc    = 1'b1;
          state_nxt    = MEM_WAIT;
        end else if (lu) begin
          // Branch operands are not valid yet, so a taken branch waits too.
          pipe_stall_o = 1'b0;
          stall_inc    = 1'b1;
        end else begin
          pc_write_o   = 1'b1;
          ifid_write_o = 1'b1;
          ctrl_flush_o = 1'b0;
          pipe_stall_o = 1'b0;
          if (branch_taken_i) begin
            ifid_flush_o = 1'b1;
            flush_inc    = 1'b1;
          end
        end
      end
      MEM_WAIT: begin
        ctrl_flush_o = 1'b0;
        stall_inc    = 1'b1;
        if (mem_ready_i) begin
          state_nxt = RUN;
        end else if (wait_inc >= 9'(MEM_TIMEOUT)) begin
          state_nxt = ERR;
        end
      end
      ERR: begin
        state_nxt = ERR;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      wait_cnt <= '0;
      err_o    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == RUN && mm) begin
        wait_cnt <= WAIT_W'(1);
      end else if (state == MEM_WAIT && !mem_ready_i) begin
        wait_cnt <= WAIT_W'(wait_inc);
      end
      if (state_nxt == ERR) err_o <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk_i),
    .inc (stall_inc),
    .clr (rst_i),
    .q   (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk_i),
    .inc (flush_inc),
    .clr (rst_i),
    .q   (flush_cnt_o)
  );

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: vector table in RUN plus hand sequences
// for memory wait, timeout/error, reset recovery and counter saturation.
module tb_hazard_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic [4:0] rs1, rs2, rd;
  logic       uses2, memread, br, req, rdy;

  logic        pc_a, iw_a, if_a, cf_a, st_a, err_a;
  logic [15:0] scnt_a, fcnt_a;
  logic        pc_b, iw_b, if_b, cf_b, st_b, err_b;
  logic [15:0] scnt_b, fcnt_b;

  int checks = 0;
  int errors = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  hazard_sequencer u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .id_rs1_i(rs1), .id_rs2_i(rs2), .id_uses_rs2_i(uses2),
    .ex_memread_i(memread), .ex_rd_i(rd), .branch_taken_i(br),
    .mem_req_i(req), .mem_ready_i(rdy),
    .pc_write_o(pc_a), .ifid_write_o(iw_a), .ifid_flush_o(if_a),
    .ctrl_flush_o(cf_a), .pipe_stall_o(st_a),
    .stall_cnt_o(scnt_a), .flush_cnt_o(fcnt_a), .err_o(err_a)
  );

  hazard_sequencer #(.CNT_W(16), .MEM_TIMEOUT(4)) u_to (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .id_rs1_i(rs1), .id_rs2_i(rs2), .id_uses_rs2_i(uses2),
    .ex_memread_i(memread), .ex_rd_i(rd), .branch_taken_i(br),
    .mem_req_i(req), .mem_ready_i(rdy),
    .pc_write_o(pc_b), .ifid_write_o(iw_b), .ifid_flush_o(if_b),
    .ctrl_flush_o(cf_b), .pipe_stall_o(st_b),
    .stall_cnt_o(scnt_b), .flush_cnt_o(fcnt_b), .err_o(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       memread;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses2;
    logic       br;
    logic       req;
    logic       rdy;
    logic [4:0] outs;   // {pc_write, ifid_write, ifid_flush, ctrl_flush, pipe_stall}
    int         dstall;
    int         dflush;
  } vec_t;

  vec_t vecs[10];

  localparam logic [4:0] O_RUN   = 5'b11000;
  localparam logic [4:0] O_LU    = 5'b00010;
  localparam logic [4:0] O_BR    = 5'b11100;
  localparam logic [4:0] O_MEM   = 5'b00001;
  localparam logic [4:0] O_FROZE = 5'b00011;

  function automatic logic [4:0] outs_a();
    return {pc_a, iw_a, if_a, cf_a, st_a};
  endfunction

  function automatic logic [4:0] outs_b();
    return {pc_b, iw_b, if_b, cf_b, st_b};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic m, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic u, input logic b,
                        input logic q, input logic r);
    memread = m; rd = d; rs1 = s1; rs2 = s2; uses2 = u; br = b; req = q; rdy = r;
  endtask

  initial begin
    //            mr    rd    rs1   rs2   u2    br    req   rdy   outs   ds fl
    vecs[0] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN, 0, 0};
    vecs[1] = '{1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_LU,  1, 0};
    vecs[2] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_RUN, 0, 0};
    vecs[3] = '{1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN, 0, 0};
    vecs[4] = '{1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, O_LU,  1, 0};
    vecs[5] = '{1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, O_LU,  1, 0};
    vecs[6] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, O_BR,  0, 1};
    vecs[7] = '{1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN, 0, 0};
    vecs[8] = '{1'b1, 5'd9, 5'd9, 5'd1, 1'b0, 1'b1, 1'b1, 1'b1, O_LU,  1, 0};
    vecs[9] = '{1'b0, 5'd9, 5'd9, 5'd1, 1'b1, 1'b1, 1'b1, 1'b1, O_BR,  0, 1};

    rst = 1'b1;
    start = 1'b0;
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) tick();
    rst = 1'b0;

    // Reset state and IDLE outputs; a hazard seen in IDLE must not count.
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    check("idle_outs", 32'(outs_a()), 32'(O_FROZE));
    check("rst_stall_cnt", 32'(scnt_a), 32'd0);
    check("rst_flush_cnt", 32'(fcnt_a), 32'd0);
    check("rst_err", 32'(err_a), 32'd0);
    tick();
    check("idle_flush_frozen", 32'(fcnt_a), 32'd0);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    #1;
    check("start_cycle_outs", 32'(outs_a()), 32'(O_FROZE));
    tick();
    start = 1'b0;
    #1;
    check("first_run_outs", 32'(outs_a()), 32'(O_RUN));

    // Single-cycle RUN vectors.
    for (int i = 0; i < 10; i++) begin
      set_in(vecs[i].memread, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
             vecs[i].uses2, vecs[i].br, vecs[i].req, vecs[i].rdy);
      #1;
      check($sformatf("vec%0d_outs", i), 32'(outs_a()), 32'(vecs[i].outs));
      tick();
      exp_stall += vecs[i].dstall;
      exp_flush += vecs[i].dflush;
      check($sformatf("vec%0d_stall_cnt", i), 32'(scnt_a), 32'(exp_stall));
      check($sformatf("vec%0d_flush_cnt", i), 32'(fcnt_a), 32'(exp_flush));
    end

    // Memory wait: miss beats load-use, 3 not-ready cycles then ready.
    set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) begin
      if (c == 3) rdy = 1'b1;
      #1;
      check($sformatf("memwait%0d_outs", c), 32'(outs_a()), 32'(O_MEM));
      tick();
    end
    exp_stall += 4;
    check("memwait_stall_cnt", 32'(scnt_a), 32'(exp_stall));
    check("memwait_flush_cnt", 32'(fcnt_a), 32'(exp_flush));
    check("to4_no_err_at_3", 32'(err_b), 32'd0);
    req = 1'b0;
    rdy = 1'b0;
    #1;
    check("post_wait_lu_outs", 32'(outs_a()), 32'(O_LU));
    tick();
    exp_stall += 1;
    check("post_wait_lu_cnt", 32'(scnt_a), 32'(exp_stall));
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("back_to_run_outs", 32'(outs_a()), 32'(O_RUN));
    tick();

    // Timeout: the MEM_TIMEOUT=4 instance errors after four wait cycles.
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) tick();
    check("to_err_before", 32'(err_b), 32'd0);
    tick();
    check("to_err_set", 32'(err_b), 32'd1);
    check("to_err_outs", 32'(outs_b()), 32'(O_FROZE));
    check("long_timeout_no_err", 32'(err_a), 32'd0);
    check("long_timeout_stall", 32'(outs_a()), 32'(O_MEM));
    req = 1'b0;
    rdy = 1'b1;
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    check("to_err_sticky", 32'(err_b), 32'd1);
    check("to_err_outs_sticky", 32'(outs_b()), 32'(O_FROZE));

    // Reset recovery.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_clears_err", 32'(err_b), 32'd0);
    check("rst_clears_stall", 32'(scnt_a), 32'd0);
    check("rst_clears_flush", 32'(fcnt_a), 32'd0);
    check("rst_idle_outs", 32'(outs_b()), 32'(O_FROZE));

    // Saturation: hold a load-use hazard in RUN for more than 2^16 cycles.
    set_in(1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("sat_start_cnt", 32'(scnt_a), 32'd0);
    repeat (65534) tick();
    check("sat_fffe", 32'(scnt_a), 32'h0000FFFE);
    tick();
    check("sat_ffff", 32'(scnt_a), 32'h0000FFFF);
    repeat (3) tick();
    check("sat_hold", 32'(scnt_a), 32'h0000FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Pipeline hazard and stall controller for the 5-stage RISC-V core.
- Decides each cycle whether the pipeline runs, freezes for a data-memory wait, inserts a load-use bubble, or flushes IF/ID after a taken branch.
- Drives the decode control unit's Flush input, the PC/IF-ID write enables and the global pipeline freeze.
- Keeps saturating performance counters and a sticky timeout error for the memory-wait path.

Parameters:
- CNT_W, 16, width of the stall and flush performance counters.
- MEM_TIMEOUT, 64, maximum consecutive memory-wait cycles before the error is raised; legal range 1..255.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous reset, active-high.
- start_i  input  1  leaves IDLE when high.
- id_rs1_i  input  5  rs1 of the instruction in ID.
- id_rs2_i  input  5  rs2 of the instruction in ID.
- id_uses_rs2_i  input  1  ID instruction reads rs2 (R-type, store, branch).
- ex_memread_i  input  1  ID/EX holds a load.
- ex_rd_i  input  5  rd held in ID/EX.
- branch_taken_i  input  1  branch resolved taken in ID this cycle.
- mem_req_i  input  1  MEM stage issues a data-memory access.
- mem_ready_i  input  1  data memory completes the access this cycle.
- pc_write_o  output  1  PC update enable.
- ifid_write_o  output  1  IF/ID register write enable.
- ifid_flush_o  output  1  zero the IF/ID instruction.
- ctrl_flush_o  output  1  to Control Flush_in; turns the ID instruction into a bubble.
- pipe_stall_o  output  1  freezes ID/EX, EX/MEM and MEM/WB.
- stall_cnt_o  output  CNT_W  count of cycles with load-use or memory stall.
- flush_cnt_o  output  CNT_W  count of taken-branch flushes.
- err_o  output  1  sticky memory-timeout error.

Behaviour:
- FSM states:
  - IDLE: all enables low, counters frozen.
  - RUN
  - MEM_WAIT
  - ERR
- Reset: state=IDLE; stall_cnt_o=0; flush_cnt_o=0; err_o=0; wait counter=0.
- Outputs in IDLE/ERR: pc_write_o=0, ifid_write_o=0, pipe_stall_o=1, ctrl_flush_o=1, ifid_flush_o=0.
- IDLE -> RUN: when start_i=1; takes effect next cycle.
- Outputs are combinational from the current state and inputs, with zero latency. A stall or flush applies in the same cycle in which its condition is present.
- Load-use condition (lu): ex_memread_i AND ex_rd_i!=0 AND (ex_rd_i==id_rs1_i OR (id_uses_rs2_i AND ex_rd_i==id_rs2_i)).
- Memory miss (mm): mem_req_i AND NOT mem_ready_i.
- RUN priority, highest first:
  - (1) mm: pipe_stall_o=1, pc_write_o=0, ifid_write_o=0, ctrl_flush_o=0, ifid_flush_o=0; next=MEM_WAIT; wait counter loads 1.
  - (2) lu: pc_write_o=0, ifid_write_o=0, ctrl_flush_o=1, pipe_stall_o=0. branch_taken_i is ignored, because the branch operands are not valid yet.
  - (3) branch_taken_i: ifid_flush_o=1, pc_write_o=1, ifid_write_o=1; flush_cnt_o increments.
  - (4) otherwise: pc_write_o=1, ifid_write_o=1, all flush/stall outputs 0.
- MEM_WAIT:
  - Outputs are the same as case (1); lu and branch_taken_i are ignored.
  - When mem_ready_i=1: outputs are those of case (1) for that cycle, and next=RUN. The following RUN cycle re-evaluates lu and branch normally.
  - When mem_ready_i=0: the wait counter increments. If the wait counter reaches MEM_TIMEOUT, next=ERR and err_o=1 from the next cycle on.
- ERR: left only by rst_i.
- stall_cnt_o: +1 in every RUN cycle with mm or lu, and in every MEM_WAIT cycle. Saturates at all-ones; no wrap.
- flush_cnt_o: saturates at all-ones.
- A load-use stall lasts exactly one cycle, because the bubble clears ex_memread_i.
- Reset asserted in any state, including mid-MEM_WAIT: return to IDLE next cycle and clear all counters and err_o.

Decomposition:
- Shared package core_pkg holds:
  - the state enum (IDLE, RUN, MEM_WAIT, ERR);
  - the register-index width constant (5);
  - the zero-register constant.
- One sub-module: sat_counter (parameter W; inputs inc and clr; saturating output). It is instantiated twice, for stall_cnt_o and flush_cnt_o.
- The wait counter is inline, sized by $clog2(MEM_TIMEOUT+1).

Test Plan:
- Reset then start_i=1: IDLE outputs are pc_write_o=0, pipe_stall_o=1, ctrl_flush_o=1. In the next cycle (RUN, no hazards): pc_write_o=1, ifid_write_o=1, other outputs 0.
- ex_memread_i=1, ex_rd_i=5, id_rs1_i=5: one cycle with pc_write_o=0, ifid_write_o=0, ctrl_flush_o=1, stall_cnt_o 0->1. Repeat with ex_rd_i=0: no stall.
- Load-use on rs2 (ex_rd_i=7, id_rs2_i=7): stall only when id_uses_rs2_i=1. Same cycle with branch_taken_i=1: ifid_flush_o=0, flush_cnt_o unchanged.
- branch_taken_i=1 alone: ifid_flush_o=1, pc_write_o=1, flush_cnt_o +1.
- mem_req_i=1 with mem_ready_i low for 3 cycles, then high: pipe_stall_o=1 for 4 cycles, state returns to RUN, stall_cnt_o +4. Load-use present during the wait is ignored, then stalls 1 cycle after the wait.
- MEM_TIMEOUT=4 with mem_ready_i never asserted: err_o=1 after the timeout and stays high. rst_i=1 clears err_o, the counters, and returns to IDLE. Separately, force stall_cnt_o to saturate at 16'hFFFF with CNT_W=16.
